// File: rtl/mod_alu_pkg.sv
// Shared encodings for the sequential modular ALU.
// Opcodes, FSM states and the iteration counter sizing rule.
package mod_alu_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_SUB = 2'd1,
      OP_MUL = 2'd2,
      OP_INV = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic int cnt_bits(input int w);
      return $clog2(2 * w + 2);
   endfunction

endpackage

// File: rtl/mod_addsub_unit.sv
// Modular add/subtract of two residues already below p.
// One conditional correction by p yields a fully reduced result.
module mod_addsub_unit #(
   parameter int DATAWIDTH = 8
) (
   input  logic [DATAWIDTH-1:0] a,
   input  logic [DATAWIDTH-1:0] b,
   input  logic [DATAWIDTH-1:0] p,
   input  logic                 sub,
   output logic [DATAWIDTH-1:0] r
);

   localparam int W = DATAWIDTH;

   logic [W:0]   sum;
   logic [W:0]   dif;
   logic [W-1:0] sum_red;
   logic [W-1:0] dif_fix;

   assign sum     = {1'b0, a} + {1'b0, b};
   assign dif     = {1'b0, a} - {1'b0, b};
   assign sum_red = sum[W-1:0] - p;
   assign dif_fix = dif[W-1:0] + p;

   always_comb begin
      r = sum[W-1:0];
      if (sub) begin
         r = dif[W] ? dif_fix : dif[W-1:0];
      end else if (sum >= {1'b0, p}) begin
         r = sum_red;
      end
   end

endmodule

// File: rtl/mod_alu_seq.sv
// Sequential modular ALU: ADD/SUB in one step, MUL by double-and-add,
// INV by binary extended Euclid, valid/ready on both sides.
module mod_alu_seq
   import mod_alu_pkg::*;
#(
   parameter int DATAWIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [1:0]           op,
   input  logic [DATAWIDTH-1:0] a,
   input  logic [DATAWIDTH-1:0] b,
   input  logic [DATAWIDTH-1:0] p,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATAWIDTH-1:0] r,
   output logic                 err
);

   localparam int W  = DATAWIDTH;
   localparam int CW = cnt_bits(DATAWIDTH);
   localparam logic [CW-1:0] MUL_LAST = CW'(DATAWIDTH - 1);
   localparam logic [W-1:0]  ONE      = W'(1);

   state_e        st, st_d;
   op_e           op_q, op_d;
   logic [W-1:0]  u_q, u_d;
   logic [W-1:0]  v_q, v_d;
   logic [W-1:0]  b_q, b_d;
   logic [W-1:0]  p_q, p_d;
   logic [W-1:0]  x1_q, x1_d;
   logic [W-1:0]  x2_q, x2_d;
   logic [W-1:0]  r_q, r_d;
   logic          err_q, err_d;
   logic [CW-1:0] cnt, cnt_d;

   logic [W-1:0]  ua, ub, up, u0r, u1r, macc;
   logic          usub;

   // (x + p) / 2 for odd x, with p odd: (x>>1) + (p>>1) + 1
   function automatic logic [W-1:0] half(
      input logic [W-1:0] x,
      input logic [W-1:0] m
   );
      return (x >> 1) + (x[0] ? (m >> 1) + ONE : '0);
   endfunction

   mod_addsub_unit #(.DATAWIDTH(W)) u_as0 (
      .a   (ua),
      .b   (ub),
      .p   (up),
      .sub (usub),
      .r   (u0r)
   );

   mod_addsub_unit #(.DATAWIDTH(W)) u_as1 (
      .a   (u0r),
      .b   (b_q),
      .p   (p_q),
      .sub (1'b0),
      .r   (u1r)
   );

   assign macc = u_q[W-1] ? u1r : u0r;

   always_comb begin
      st_d  = st;
      op_d  = op_q;
      u_d   = u_q;
      v_d   = v_q;
      b_d   = b_q;
      p_d   = p_q;
      x1_d  = x1_q;
      x2_d  = x2_q;
      r_d   = r_q;
      err_d = err_q;
      cnt_d = cnt;
      ua    = x1_q;
      ub    = x2_q;
      up    = p_q;
      usub  = 1'b0;
      unique case (st)
         IDLE: begin
            ua   = a;
            ub   = b;
            up   = p;
            usub = (op == OP_SUB);
            if (in_valid) begin
               op_d  = op_e'(op);
               u_d   = a;
               v_d   = p;
               b_d   = b;
               p_d   = p;
               x1_d  = ONE;
               x2_d  = '0;
               cnt_d = '0;
               err_d = 1'b0;
               unique case (op_e'(op))
                  OP_ADD, OP_SUB: begin
                     r_d  = u0r;
                     st_d = DONE;
                  end
                  OP_MUL: begin
                     x1_d = '0;
                     st_d = BUSY;
                  end
                  OP_INV: begin
                     if (a == '0) begin
                        r_d   = '0;
                        err_d = 1'b1;
                        st_d  = DONE;
                     end else begin
                        st_d = BUSY;
                     end
                  end
               endcase
            end
         end
         BUSY: begin
            cnt_d = cnt + CW'(1);
            if (op_q == OP_MUL) begin
               ua   = x1_q;
               ub   = x1_q;
               x1_d = macc;
               u_d  = u_q << 1;
               if (cnt == MUL_LAST) begin
                  r_d  = macc;
                  st_d = DONE;
               end
            end else if (u_q == ONE) begin
               r_d  = x1_q;
               st_d = DONE;
            end else if (v_q == ONE) begin
               r_d  = x2_q;
               st_d = DONE;
            end else if (cnt == '1) begin
               r_d  = x1_q;
               st_d = DONE;
            end else if (!u_q[0]) begin
               u_d  = u_q >> 1;
               x1_d = half(x1_q, p_q);
            end else if (!v_q[0]) begin
               v_d  = v_q >> 1;
               x2_d = half(x2_q, p_q);
            end else if (u_q >= v_q) begin
               u_d  = u_q - v_q;
               usub = 1'b1;
               x1_d = u0r;
            end else begin
               v_d  = v_q - u_q;
               ua   = x2_q;
               ub   = x1_q;
               usub = 1'b1;
               x2_d = u0r;
            end
         end
         DONE: begin
            if (out_ready) begin
               st_d = IDLE;
            end
         end
         default: st_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st    <= IDLE;
         op_q  <= OP_ADD;
         u_q   <= '0;
         v_q   <= '0;
         b_q   <= '0;
         p_q   <= '0;
         x1_q  <= '0;
         x2_q  <= '0;
         r_q   <= '0;
         err_q <= 1'b0;
         cnt   <= '0;
      end else begin
         st    <= st_d;
         op_q  <= op_d;
         u_q   <= u_d;
         v_q   <= v_d;
         b_q   <= b_d;
         p_q   <= p_d;
         x1_q  <= x1_d;
         x2_q  <= x2_d;
         r_q   <= r_d;
         err_q <= err_d;
         cnt   <= cnt_d;
      end
   end

   assign in_ready  = (st == IDLE);
   assign out_valid = (st == DONE);
   assign r         = r_q;
   assign err       = err_q;

endmodule

// File: tb/tb_mod_alu_seq.sv
// Directed table, handshake corner cases and a random sweep
// against a behavioural modular-arithmetic model.
module tb_mod_alu_seq;

   localparam int W = 8;
   localparam int TMO = 64;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [1:0]   op = 2'd0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic [W-1:0] p = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] r;
   logic         err;

   int ncomp = 0;
   int nfail = 0;

   mod_alu_seq #(.DATAWIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .p         (p),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .r         (r),
      .err       (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] op;
      int         a;
      int         b;
      int         p;
      int         r;
      int         err;
      int         lat;
      bit         exact;
      string      name;
   } vec_t;

   vec_t vt[14];

   function automatic vec_t mk(input logic [1:0] o, input int x,
                               input int y, input int m, input int rr,
                               input int ee, input int l, input bit ex,
                               input string n);
      vec_t v;
      v.op = o; v.a = x; v.b = y; v.p = m; v.r = rr;
      v.err = ee; v.lat = l; v.exact = ex; v.name = n;
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      ncomp++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic ref_model(input logic [1:0] o, input int x, input int y,
                            input int m, output int rr, output int ee);
      ee = 0;
      rr = 0;
      case (o)
         2'd0: rr = (x + y) % m;
         2'd1: rr = (x - y + m) % m;
         2'd2: rr = (x * y) % m;
         default: begin
            if (x == 0) ee = 1;
            else for (int k = 1; k < m; k++)
               if ((x * k) % m == 1) rr = k;
         end
      endcase
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic start(input logic [1:0] o, input int x, input int y,
                        input int m);
      @(negedge clk);
      in_valid = 1'b1;
      op = o;
      a = x[W-1:0];
      b = y[W-1:0];
      p = m[W-1:0];
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      p = W'($urandom);
      op = 2'($urandom);
   endtask

   task automatic wait_valid(output int lat, output bit to);
      lat = 0;
      to = 1'b0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < TMO);
      if (!out_valid) to = 1'b1;
   endtask

   task automatic take();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic run(input logic [1:0] o, input int x, input int y,
                      input int m, output int rr, output int ee,
                      output int lat, output bit to);
      start(o, x, y, m);
      wait_valid(lat, to);
      rr = int'(r);
      ee = int'(err);
      if (to) begin
         ncomp++;
         nfail++;
         $display("FAIL timeout: out_valid got 0 expected 1 op=%0d", o);
         do_reset();
      end else begin
         take();
      end
   endtask

   initial begin
      int rr, ee, lat, er, eerr;
      bit to, seen;
      int pr[6];

      #1;
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_r", int'(r), 0);
      chk("rst_err", int'(err), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_in_ready", int'(in_ready), 1);

      vt[0]  = mk(2'd0, 200, 100, 251, 49, 0, 1, 1, "add200_100");
      vt[1]  = mk(2'd1, 3, 10, 251, 244, 0, 1, 1, "sub3_10");
      vt[2]  = mk(2'd2, 123, 45, 251, 13, 0, 9, 1, "mul123_45");
      vt[3]  = mk(2'd3, 2, 0, 251, 126, 0, 17, 0, "inv2");
      vt[4]  = mk(2'd3, 250, 0, 251, 250, 0, 17, 0, "inv250");
      vt[5]  = mk(2'd3, 0, 0, 251, 0, 1, 1, 1, "inv0");
      vt[6]  = mk(2'd0, 250, 250, 251, 249, 0, 1, 1, "add_max");
      vt[7]  = mk(2'd1, 5, 5, 251, 0, 0, 1, 1, "sub_eq");
      vt[8]  = mk(2'd2, 250, 250, 251, 1, 0, 9, 1, "mul_max");
      vt[9]  = mk(2'd2, 0, 77, 251, 0, 0, 9, 1, "mul_zero");
      vt[10] = mk(2'd0, 12, 12, 13, 11, 0, 1, 1, "add_p13");
      vt[11] = mk(2'd2, 7, 8, 13, 4, 0, 9, 1, "mul_p13");
      vt[12] = mk(2'd3, 3, 0, 13, 9, 0, 17, 0, "inv3_p13");
      vt[13] = mk(2'd0, 0, 0, 251, 0, 0, 1, 1, "add_zero");

      foreach (vt[i]) begin
         run(vt[i].op, vt[i].a, vt[i].b, vt[i].p, rr, ee, lat, to);
         if (!to) begin
            chk({vt[i].name, "_r"}, rr, vt[i].r);
            chk({vt[i].name, "_err"}, ee, vt[i].err);
            if (vt[i].exact) chk({vt[i].name, "_lat"}, lat, vt[i].lat);
            else chk({vt[i].name, "_lat_ok"}, int'(lat <= vt[i].lat), 1);
         end
      end

      start(2'd2, 10, 20, 251);
      wait_valid(lat, to);
      chk("hold_arrive", int'(out_valid), 1);
      for (int i = 0; i < 5; i++) begin
         chk("hold_r", int'(r), 200);
         chk("hold_err", int'(err), 0);
         chk("hold_in_ready", int'(in_ready), 0);
         chk("hold_out_valid", int'(out_valid), 1);
         in_valid = 1'b1;
         op = 2'd0;
         a = 8'd1;
         b = 8'd1;
         p = 8'd251;
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("hold_r_end", int'(r), 200);
      take();
      @(negedge clk);
      chk("hold_back_idle", int'(in_ready), 1);
      run(2'd0, 7, 8, 251, rr, ee, lat, to);
      if (!to) chk("after_hold_r", rr, 15);

      start(2'd2, 123, 45, 251);
      repeat (4) @(negedge clk);
      chk("mul_mid_busy", int'(in_ready), 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", int'(out_valid), 0);
      chk("arst_in_ready", int'(in_ready), 1);
      chk("arst_r", int'(r), 0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      chk("arst_no_result", int'(seen), 0);
      chk("arst_ready_after", int'(in_ready), 1);
      run(2'd2, 123, 45, 251, rr, ee, lat, to);
      if (!to) begin
         chk("arst_fresh_r", rr, 13);
         chk("arst_fresh_lat", lat, 9);
      end

      pr = '{251, 13, 241, 3, 7, 127};
      for (int i = 0; i < 60; i++) begin
         int m, x, y;
         logic [1:0] o;
         m = pr[$urandom_range(0, 5)];
         x = int'($urandom_range(0, m - 1));
         y = int'($urandom_range(0, m - 1));
         o = 2'($urandom_range(0, 3));
         ref_model(o, x, y, m, er, eerr);
         run(o, x, y, m, rr, ee, lat, to);
         if (!to) begin
            chk($sformatf("rnd%0d_op%0d_r", i, o), rr, er);
            chk($sformatf("rnd%0d_op%0d_err", i, o), ee, eerr);
            if (o == 2'd3 && x != 0)
               chk($sformatf("rnd%0d_inv_prod", i), (x * rr) % m, 1);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               ncomp, nfail);
      $finish;
   end

endmodule
